// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response port of the fetch stage.
// The master side issues req/addr; the slave side answers with ready/rdata.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, one-deep stall buffer and redirect handling.
// Define IF_STATIC_PREDICT_EN to enable static JAL / backward-branch prediction (IF_ID_take).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ID_stall,
    input  logic                   EX_redirect,
    input  logic [31:0]            EX_redirect_pc,
    if_fetch_stage_if.master       imem,
    output logic [31:0]            IF_ID_instruction,
    output logic [31:0]            IF_ID_pc,
    output logic                   IF_ID_valid,
    output logic                   IF_ID_take
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_BUF   = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic        r_if_id_valid;
    logic        r_if_id_take;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic        r_buf_take;

    logic [31:0] w_next_pc;
    logic        w_pred_take;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = {EX_redirect_pc[31:2], 2'b00};

`ifdef IF_STATIC_PREDICT_EN
    logic [6:0]  w_opcode;
    logic [31:0] w_j_imm;
    logic [31:0] w_b_imm;

    assign w_opcode = imem.imem_rdata[6:0];
    assign w_j_imm  = {{12{imem.imem_rdata[31]}}, imem.imem_rdata[19:12], imem.imem_rdata[20],
                       imem.imem_rdata[30:21], 1'b0};
    assign w_b_imm  = {{20{imem.imem_rdata[31]}}, imem.imem_rdata[7], imem.imem_rdata[30:25],
                       imem.imem_rdata[11:8], 1'b0};

    // Only JAL and backward conditional branches are predicted taken.
    always_comb begin
        w_next_pc   = r_pc + 32'd4;
        w_pred_take = 1'b0;
        if (w_opcode == 7'b1101111) begin
            w_next_pc   = r_pc + w_j_imm;
            w_pred_take = 1'b1;
        end else if (w_opcode == 7'b1100011 && imem.imem_rdata[31]) begin
            w_next_pc   = r_pc + w_b_imm;
            w_pred_take = 1'b1;
        end
    end
`else
    assign w_next_pc   = r_pc + 32'd4;
    assign w_pred_take = 1'b0;
`endif

    // In DROP the abandoned request must stay on the bus until memory answers it.
    assign imem.imem_req  = (r_state != S_BUF);
    assign imem.imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

    assign IF_ID_instruction = r_if_id_instr;
    assign IF_ID_pc          = r_if_id_pc;
    assign IF_ID_valid       = r_if_id_valid;
    assign IF_ID_take        = r_if_id_take;

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking assignments would make the result order dependent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_drop_addr   <= 32'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= 32'd0;
            r_if_id_valid <= 1'b0;
            r_if_id_take  <= 1'b0;
            r_buf_instr   <= NOP_INSTR;
            r_buf_pc      <= 32'd0;
            r_buf_take    <= 1'b0;
        end else if (EX_redirect) begin
            r_pc          <= w_redirect_pc;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_if_id_take  <= 1'b0;
            r_buf_instr   <= NOP_INSTR;
            r_buf_take    <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (imem.imem_ready) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state     <= S_DROP;
                        r_drop_addr <= r_pc;
                    end
                end
                S_BUF:   r_state <= S_FETCH;
                S_DROP:  r_state <= imem.imem_ready ? S_FETCH : S_DROP;
                default: r_state <= S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem.imem_ready) begin
                        r_pc <= w_next_pc;
                        if (!ID_stall) begin
                            r_if_id_instr <= imem.imem_rdata;
                            r_if_id_pc    <= r_pc;
                            r_if_id_valid <= 1'b1;
                            r_if_id_take  <= w_pred_take;
                        end else begin
                            r_buf_instr <= imem.imem_rdata;
                            r_buf_pc    <= r_pc;
                            r_buf_take  <= w_pred_take;
                            r_state     <= S_BUF;
                        end
                    end else if (!ID_stall) begin
                        r_if_id_instr <= NOP_INSTR;
                        r_if_id_valid <= 1'b0;
                        r_if_id_take  <= 1'b0;
                    end
                end
                S_BUF: begin
                    if (!ID_stall) begin
                        r_if_id_instr <= r_buf_instr;
                        r_if_id_pc    <= r_buf_pc;
                        r_if_id_valid <= 1'b1;
                        r_if_id_take  <= r_buf_take;
                        r_state       <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem.imem_ready) begin
                        r_state <= S_FETCH;
                    end
                    if (!ID_stall) begin
                        r_if_id_instr <= NOP_INSTR;
                        r_if_id_valid <= 1'b0;
                        r_if_id_take  <= 1'b0;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule
